// File: rtl/addsub4_sweep_checker.sv
// addsub4_sweep_checker
//
// Exhaustive stimulus/response checker for a 4-bit add/subtract unit.
// A start request sweeps all 512 {op, a, b} combinations, one per cycle.
// Each response is compared against a built-in golden model after DUT_LAT
// cycles. The checker reports the error count, pass/fail and the first
// failing vector.
//
// Parameters
//   DUT_LAT    : cycles from operands driven to DUT response valid (0..4)
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begin a sweep (honoured only in IDLE or DONE)
//   dut_sum    : DUT sum result
//   dut_cout   : DUT carry out
//   op, a, b   : registered operands presented to the DUT (op 1 = subtract)
//   c_in       : DUT carry in, tied to 0
//   busy       : sweep or drain in progress
//   done       : sweep finished, results held
//   pass       : valid with done, 1 when no mismatches were seen
//   err_cnt    : mismatch count of the current or last sweep
//   fail_valid : a failing vector has been captured
//   fail_vec   : {op, a, b} of the first mismatch
module addsub4_sweep_checker #(
   parameter int DUT_LAT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] dut_sum,
   input  logic       dut_cout,
   output logic       op,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic       c_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [9:0] err_cnt,
   output logic       fail_valid,
   output logic [8:0] fail_vec
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t           state;
   // Stage 0 is the operand register itself; stage DUT_LAT lines up with
   // the DUT response.
   logic [8:0]       vec_pipe [0:DUT_LAT];
   logic [DUT_LAT:0] vld_pipe;
   logic [2:0]       drain_cnt;

   logic [8:0]       cmp_vec;
   logic             cmp_vld;
   logic [4:0]       exp_res;
   logic             mismatch;
   logic [9:0]       err_next;

   // Subtraction is a + ~b + 1, so the carry out means "no borrow".
   function automatic logic [4:0] golden(input logic [8:0] v);
      logic [3:0] bx;
      bx = v[3:0] ^ {4{v[8]}};
      return {1'b0, v[7:4]} + {1'b0, bx} + {4'd0, v[8]};
   endfunction

   assign cmp_vec  = vec_pipe[DUT_LAT];
   assign cmp_vld  = vld_pipe[DUT_LAT];
   assign exp_res  = golden(cmp_vec);
   assign mismatch = cmp_vld && ({dut_cout, dut_sum} != exp_res);
   assign err_next = err_cnt + {9'd0, mismatch};

   assign {op, a, b} = vec_pipe[0];
   assign c_in       = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         vld_pipe   <= '0;
         for (int i = 0; i <= DUT_LAT; i++) vec_pipe[i] <= '0;
         drain_cnt  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
      end else begin
         // Compare pipe advances every cycle; stage 0 is loaded by the FSM.
         for (int i = 1; i <= DUT_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            vec_pipe[i] <= vec_pipe[i-1];
         end

         if (mismatch) begin
            err_cnt <= err_next;
            if (!fail_valid) begin
               fail_valid <= 1'b1;
               fail_vec   <= cmp_vec;
            end
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state       <= S_RUN;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  err_cnt     <= '0;
                  fail_valid  <= 1'b0;
                  fail_vec    <= '0;
                  vld_pipe    <= '0;
                  vld_pipe[0] <= 1'b1;
                  vec_pipe[0] <= '0;
               end else if (state == S_IDLE) begin
                  err_cnt    <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
                  vld_pipe   <= '0;
               end
            end
            S_RUN: begin
               if (vec_pipe[0] == 9'd511) begin
                  vld_pipe[0] <= 1'b0;
                  if (DUT_LAT > 0) begin
                     state     <= S_DRAIN;
                     drain_cnt <= 3'(DUT_LAT - 1);
                  end else begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == 10'd0);
                  end
               end else begin
                  vec_pipe[0] <= vec_pipe[0] + 9'd1;
               end
            end
            S_DRAIN: begin
               // The last in-flight vector is compared on the exit edge.
               if (drain_cnt == 3'd0) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == 10'd0);
               end else begin
                  drain_cnt <= drain_cnt - 3'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/addsub4_sweep_checker.md
# addsub4_sweep_checker

Self-checking stimulus and response block for the 4-bit add/subtract unit (`addSub4`). It drives the unit's operand side (`op`, `a`, `b`, `c_in`) and receives its result side (`sum`, `c_out`). On `start` it sweeps all 512 `{op, a, b}` combinations, one per cycle. Each DUT response is compared against an internal golden model after a programmable latency. It reports pass/fail, an error count and the first failing vector, so adder variants can be checked in hardware without a simulator monitor.

## Interface
Parameters
- `DUT_LAT`, default 0: cycles from operands on the outputs to the DUT response being valid on the inputs. Legal range 0..4; 0 means a combinational DUT.

Ports
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: starts a sweep. Sampled only in IDLE or DONE.
- `dut_sum` input 4: DUT `sum`.
- `dut_cout` input 1: DUT `c_out`.
- `op` output 1: 0 = add, 1 = subtract. Registered.
- `a` output 4: operand A. Registered.
- `b` output 4: operand B. Registered.
- `c_in` output 1: constant 0 while driving.
- `busy` output 1: high in RUN and DRAIN.
- `done` output 1: high in DONE.
- `pass` output 1: valid when `done`; 1 iff `err_cnt == 0`.
- `err_cnt` output 10: number of mismatches in the current or last sweep.
- `fail_valid` output 1: a mismatch has been captured.
- `fail_vec` output 9: `{op, a, b}` of the first mismatch.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start` = 1 moves to RUN.
  - Clears the index, `err_cnt`, `fail_valid`, `fail_vec` and the latency pipe.
- RUN:
  - Each cycle presents vector `idx` as `{op, a, b} = idx[8:0]` and increments `idx`.
  - After presenting `idx = 511`: go to DRAIN if `DUT_LAT > 0`, else to DONE.
- DRAIN: lasts exactly `DUT_LAT` cycles, then moves to DONE. No new vectors are presented.
- DONE:
  - Holds all results.
  - `start` = 1 restarts: clears results and enters RUN, same as from IDLE.
- `start` is ignored in RUN and DRAIN.
- Golden model:
  - `bx = b ^ {4{op}}`
  - `exp[4:0] = {1'b0,a} + {1'b0,bx} + op`, 5-bit unsigned.
  - The DUT is correct iff `dut_sum == exp[3:0]` and `dut_cout == exp[4]`.
- Compare pipe:
  - `{valid, vector, exp}` is delayed `DUT_LAT` stages.
  - A compare happens only when the delayed `valid` = 1.
- On a mismatch:
  - `err_cnt` increments. Maximum is 512, so no saturation is needed.
  - If `fail_valid` = 0, set `fail_valid` and capture `fail_vec`.
- Operand outputs hold their last value outside RUN. `c_in` is always 0.

## Timing
- Reset values: state IDLE, `op`/`a`/`b`/`c_in` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0, `fail_valid` = 0, `fail_vec` = 0, pipe valids = 0.
- Reset mid-sweep aborts immediately to these values. There is no resume.
- Cycle numbering: `start` is sampled at edge 0.
  - Vector `k` is on the outputs during cycle `k+1`, for k = 0..511.
  - Vector `k` is compared at the end of cycle `k+1+DUT_LAT`.
- `busy` is high for cycles 1 .. 512+DUT_LAT.
- `done` rises at cycle 513+DUT_LAT. `pass` is updated in the same cycle.
- `err_cnt` updates one cycle after the compare edge, i.e. it is registered.
- The final compare is included before `done` rises.
- `start` held high continuously: one sweep per DONE→RUN transition. No restart while busy.

## Test plan
- Correct combinational model, `DUT_LAT` = 0, one `start` pulse -> `done` at cycle 513, `pass` = 1, `err_cnt` = 0, `fail_valid` = 0.
- DUT with `sum[0]` stuck at 0 -> `err_cnt` = 256, `fail_vec` = 9'd1 (op 0, a 0, b 1), `pass` = 0.
- DUT with `c_out` stuck at 0 -> `err_cnt` = 256 (120 add carries + 136 subtract carries), `fail_vec` = 9'd31 (a 1, b 15).
- Correct DUT registered twice, `DUT_LAT` = 2 -> `done` at cycle 515, `pass` = 1. The same DUT with `DUT_LAT` = 0 -> `pass` = 0.
- Deassert `rst_n` at cycle 200 of a sweep -> all outputs at reset values while low. A subsequent `start` gives a clean full sweep with `pass` = 1.
- After a failing sweep, pulse `start` in DONE with a correct DUT -> `err_cnt`/`fail_valid` clear on entry to RUN, and the sweep ends with `pass` = 1.
